// File: rtl/reg_arb_pkg.sv
// Shared definitions for the register write arbiter and its users.
package reg_arb_pkg;

    localparam int WORD_SIZE_DEF = 8;
    localparam int NUM_REQ_DEF   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ACK  = 2'd2,
        ST_CLR  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               valid
);

    localparam logic [IDX_W:0] N_W = (IDX_W+1)'(NUM_REQ);

    always_comb begin
        logic [IDX_W:0] sum;
        winner = '0;
        valid  = 1'b0;
        sum    = '0;
        // Scan from the farthest offset down so the closest one to ptr wins last.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            sum = {1'b0, ptr} + (IDX_W+1)'(i);
            if (sum >= N_W) begin
                sum = sum - N_W;
            end
            if (req[sum[IDX_W-1:0]]) begin
                winner = sum[IDX_W-1:0];
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one register write port; clear requests take priority.
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int word_size = WORD_SIZE_DEF,
    parameter int NUM_REQ   = NUM_REQ_DEF,
    parameter int IDX_W     = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*word_size-1:0] req_data,
    input  logic                         clr,
    output logic [NUM_REQ-1:0]           gnt,
    output logic [word_size-1:0]         reg_d_in,
    output logic                         reg_load,
    output logic                         reg_clr,
    output logic                         busy,
    output logic [IDX_W-1:0]             last_owner
);

    arb_state_e             state_q, state_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [IDX_W-1:0]       win_q, win_d;
    logic [IDX_W-1:0]       last_owner_q, last_owner_d;
    logic                   clr_pend_q, clr_pend_d;
    logic [word_size-1:0]   data_q, data_d;

    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_vld;
    logic [word_size-1:0]   sel_data;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .winner (pick_idx),
        .valid  (pick_vld)
    );

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                sel_data = req_data[i*word_size +: word_size];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        win_d        = win_q;
        last_owner_d = last_owner_q;
        data_d       = data_q;
        clr_pend_d   = clr_pend_q | clr;
        case (state_q)
            ST_IDLE: begin
                if (clr_pend_q || clr) begin
                    state_d    = ST_CLR;
                    clr_pend_d = 1'b0;
                end else if (pick_vld) begin
                    win_d   = pick_idx;
                    data_d  = sel_data;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: state_d = ST_ACK;
            ST_ACK: begin
                last_owner_d = win_q;
                ptr_d        = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + IDX_W'(1);
                state_d      = ST_IDLE;
            end
            ST_CLR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decode from registered state only, so req/clr never reach them combinationally.
    always_comb begin
        gnt = '0;
        if (state_q == ST_ACK) begin
            gnt[win_q] = 1'b1;
        end
    end

    assign reg_load   = (state_q == ST_LOAD);
    assign reg_clr    = (state_q == ST_CLR);
    assign busy       = (state_q != ST_IDLE);
    assign reg_d_in   = data_q;
    assign last_owner = last_owner_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            win_q        <= '0;
            last_owner_q <= '0;
            clr_pend_q   <= 1'b0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            win_q        <= win_d;
            last_owner_q <= last_owner_d;
            clr_pend_q   <= clr_pend_d;
            data_q       <= data_d;
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter with a behavioural register_unit on its outputs.
module tb_reg_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        clr;
    logic [3:0]  gnt;
    logic [7:0]  reg_d_in;
    logic        reg_load;
    logic        reg_clr;
    logic        busy;
    logic [1:0]  last_owner;
    logic [7:0]  d_out = 8'h00;

    int n_tests = 0;
    int n_fail  = 0;

    reg_write_arbiter #(
        .word_size (8),
        .NUM_REQ   (4),
        .IDX_W     (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_data   (req_data),
        .clr        (clr),
        .gnt        (gnt),
        .reg_d_in   (reg_d_in),
        .reg_load   (reg_load),
        .reg_clr    (reg_clr),
        .busy       (busy),
        .last_owner (last_owner)
    );

    always #5 clk = ~clk;

    // register_unit stand-in: synchronous clear, load-enabled register
    always @(posedge clk) begin
        if (reg_clr)       d_out <= 8'h00;
        else if (reg_load) d_out <= reg_d_in;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; req = 4'b0000; req_data = 32'h0; clr = 1'b0;
        cyc(); cyc();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_load", 32'(reg_load), 32'h0);
        chk("rst_clr", 32'(reg_clr), 32'h0);
        chk("rst_din", 32'(reg_d_in), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_owner", 32'(last_owner), 32'h0);
        rst = 1'b0;
        cyc();

        // single write from requester 0
        req = 4'b0001; req_data = 32'h0000_00A5;
        cyc();
        chk("t1_load", 32'(reg_load), 32'h1);
        chk("t1_din", 32'(reg_d_in), 32'hA5);
        chk("t1_gnt_early", 32'(gnt), 32'h0);
        cyc();
        chk("t1_gnt", 32'(gnt), 32'b0001);
        chk("t1_load_off", 32'(reg_load), 32'h0);
        chk("t1_dout", 32'(d_out), 32'hA5);
        cyc();
        req = 4'b0000;
        chk("t1_busy", 32'(busy), 32'h0);
        chk("t1_owner", 32'(last_owner), 32'h0);
        chk("t1_din_hold", 32'(reg_d_in), 32'hA5);

        // contention from a fresh pointer
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        req = 4'b1111; req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int k = 0; k < 5; k++) begin
            int w;
            w = k % 4;
            cyc();
            chk("t2_load", 32'(reg_load), 32'h1);
            chk("t2_din", 32'(reg_d_in), 32'h10 + 32'(w));
            req = 4'b1111;
            cyc();
            chk("t2_gnt", 32'(gnt), 32'h1 << w);
            cyc();
            chk("t2_idle", 32'(busy), 32'h0);
            chk("t2_owner", 32'(last_owner), 32'(w));
            req[w] = 1'b0;
        end
        req = 4'b0000;

        // clear beats a simultaneous write request (ptr=1 here)
        clr = 1'b1; req = 4'b0100; req_data = 32'h0055_0000;
        cyc();
        clr = 1'b0;
        chk("t3_clr", 32'(reg_clr), 32'h1);
        chk("t3_load", 32'(reg_load), 32'h0);
        chk("t3_gnt", 32'(gnt), 32'h0);
        cyc();
        chk("t3_dout0", 32'(d_out), 32'h0);
        chk("t3_clr_off", 32'(reg_clr), 32'h0);
        cyc();
        chk("t3_din", 32'(reg_d_in), 32'h55);
        cyc();
        chk("t3_gnt2", 32'(gnt), 32'b0100);
        chk("t3_dout", 32'(d_out), 32'h55);
        cyc();
        req = 4'b0000;
        chk("t3_owner", 32'(last_owner), 32'h2);

        // pointer wrap: ptr=3, requesters 3 and 0 pending
        req = 4'b1001; req_data = 32'h3300_0030;
        cyc();
        chk("t6_din3", 32'(reg_d_in), 32'h33);
        cyc();
        chk("t6_gnt3", 32'(gnt), 32'b1000);
        cyc();
        chk("t6_owner3", 32'(last_owner), 32'h3);
        req = 4'b0001;
        cyc();
        chk("t6_din0", 32'(reg_d_in), 32'h30);
        cyc();
        chk("t6_gnt0", 32'(gnt), 32'b0001);
        cyc();
        chk("t6_owner0", 32'(last_owner), 32'h0);
        req = 4'b0000;

        // clear pulses during LOAD and ACK of a write collapse into one CLR
        req = 4'b0010; req_data = 32'h0000_3C00;
        cyc();
        chk("t4_din", 32'(reg_d_in), 32'h3C);
        clr = 1'b1;
        cyc();
        chk("t4_gnt", 32'(gnt), 32'b0010);
        chk("t4_dout", 32'(d_out), 32'h3C);
        cyc();
        clr = 1'b0; req = 4'b0000;
        chk("t4_idle", 32'(busy), 32'h0);
        cyc();
        chk("t4_clr", 32'(reg_clr), 32'h1);
        chk("t4_clr_gnt", 32'(gnt), 32'h0);
        cyc();
        chk("t4_dout0", 32'(d_out), 32'h0);
        chk("t4_clr_off", 32'(reg_clr), 32'h0);
        cyc();
        chk("t4_single_clr", 32'(busy), 32'h0);

        // reset in the middle of a requester 3 write (ptr=2 before reset)
        req = 4'b1000; req_data = 32'h7700_0000;
        cyc();
        chk("t5_load", 32'(reg_load), 32'h1);
        rst = 1'b1; req = 4'b0000;
        cyc();
        chk("t5_gnt", 32'(gnt), 32'h0);
        chk("t5_load_off", 32'(reg_load), 32'h0);
        chk("t5_din", 32'(reg_d_in), 32'h0);
        chk("t5_busy", 32'(busy), 32'h0);
        chk("t5_owner", 32'(last_owner), 32'h0);
        rst = 1'b0;
        cyc();
        chk("t5_no_gnt", 32'(gnt), 32'h0);
        req = 4'b1001; req_data = 32'h7700_0040;
        cyc();
        chk("t5_din0", 32'(reg_d_in), 32'h40);
        cyc();
        chk("t5_gnt0", 32'(gnt), 32'b0001);
        req = 4'b0000;
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
